// File: rtl/nco_freq_meter_if.sv
// Control/result bundle between the NCO frequency meter and its host.
// The waveform sample travels with the control signals so that all of them share one clock enable.
interface nco_freq_meter_if;
  logic       enable;
  logic [7:0] sample_in;
  logic       start;
  logic       abort;
  logic       continuous;
  logic       byte_sel;
  logic [7:0] data_out;
  logic       busy;
  logic       result_valid;
  logic       done;
  logic       no_signal;

  modport master (
    output enable, sample_in, start, abort, continuous, byte_sel,
    input  data_out, busy, result_valid, done, no_signal
  );

  modport slave (
    input  enable, sample_in, start, abort, continuous, byte_sel,
    output data_out, busy, result_valid, done, no_signal
  );
endinterface

// File: rtl/nco_freq_meter.sv
// Measures NCO output frequency by counting rising MSB crossings within a fixed gate
// aligned to a first crossing. The result is scaled back to a 16-bit FCW estimate.
module nco_freq_meter #(
  parameter int GATE_LOG2 = 12
) (
  input logic              clk,
  input logic              rst_n,
  nco_freq_meter_if.slave  bus
);
  localparam int CW = GATE_LOG2 + 1;
  localparam logic [CW-1:0] GATE_LAST = CW'((1 << GATE_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  state_t          state, stateNext;
  logic            prevMsb;
  logic [CW-1:0]   gateCnt, gateCntNext;
  logic [CW-1:0]   edgeCnt, edgeCntNext;
  logic [15:0]     fcwEst, fcwEstNext;
  logic            resultValid, resultValidNext;
  logic            noSignal, noSignalNext;
  logic            edgeDet;
  logic            gateEnd;

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Edge count over 2^GATE_LOG2 cycles times 2^(16-GATE_LOG2) is edges per 2^16 cycles.
  function automatic logic [15:0] scaleSat(input logic [CW-1:0] cnt);
    logic [16:0] wide;
    wide = 17'(cnt) << (16 - GATE_LOG2);
    return wide[16] ? 16'hFFFF : wide[15:0];
  endfunction

  assign edgeDet = bus.sample_in[7] & ~prevMsb;
  assign gateEnd = (gateCnt == GATE_LAST);

  always_comb begin
    stateNext       = state;
    gateCntNext     = gateCnt;
    edgeCntNext     = edgeCnt;
    fcwEstNext      = fcwEst;
    resultValidNext = resultValid;
    noSignalNext    = noSignal;
    if (bus.abort) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: begin
          gateCntNext = '0;
          edgeCntNext = '0;
          if (bus.start) begin
            stateNext       = ARM;
            resultValidNext = 1'b0;
            noSignalNext    = 1'b0;
          end
        end
        ARM: begin
          gateCntNext = gateCnt + 1'b1;
          if (edgeDet) begin
            // Alignment edge: index 0 of the gate, deliberately not counted.
            stateNext   = GATE;
            gateCntNext = '0;
            edgeCntNext = '0;
          end else if (gateEnd) begin
            stateNext       = DONE;
            fcwEstNext      = '0;
            noSignalNext    = 1'b1;
            resultValidNext = 1'b1;
          end
        end
        GATE: begin
          gateCntNext = gateCnt + 1'b1;
          if (edgeDet) edgeCntNext = satInc(edgeCnt);
          if (gateEnd) begin
            stateNext       = DONE;
            fcwEstNext      = scaleSat(edgeCntNext);
            noSignalNext    = 1'b0;
            resultValidNext = 1'b1;
          end
        end
        DONE: begin
          gateCntNext = '0;
          edgeCntNext = '0;
          stateNext   = bus.continuous ? ARM : IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prevMsb     <= 1'b0;
      gateCnt     <= '0;
      edgeCnt     <= '0;
      fcwEst      <= '0;
      resultValid <= 1'b0;
      noSignal    <= 1'b0;
    end else if (bus.enable) begin
      state       <= stateNext;
      prevMsb     <= bus.sample_in[7];
      gateCnt     <= gateCntNext;
      edgeCnt     <= edgeCntNext;
      fcwEst      <= fcwEstNext;
      resultValid <= resultValidNext;
      noSignal    <= noSignalNext;
    end
  end

  assign bus.busy         = (state == ARM) || (state == GATE);
  assign bus.done         = (state == DONE);
  assign bus.result_valid = resultValid;
  assign bus.no_signal    = noSignal;
  assign bus.data_out     = bus.byte_sel ? fcwEst[15:8] : fcwEst[7:0];
endmodule

// File: tb/tb_nco_freq_meter.sv
// Scoreboard bench for nco_freq_meter: waveform generator, plain-arithmetic reference model,
// and a monitor that checks every done pulse against the queued expectation.
module tb_nco_freq_meter;
  localparam int G = 12;
  localparam int N = 1 << G;

  typedef struct {
    logic [15:0] fcw;
    bit          nosig;
    int          stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nco_freq_meter_if bus();
  nco_freq_meter #(.GATE_LOG2(G)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          checks = 0;
  int          errors = 0;
  int          enCnt = 0;
  int          genStep = 0;
  int          kind = 0;
  logic [15:0] fcw = 16'h0;
  logic [15:0] ph0 = 16'h0;
  bit          cont = 1'b0;
  bit          bsel = 1'b0;
  exp_t        q[$];
  exp_t        me;
  bit          prevDone = 1'b0;
  int          lowCheckAt = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // kind: 0 unsigned sawtooth, 1 two's-complement sine, 2 square 00/FF, 3 constant zero
  function automatic logic [7:0] sampleOf(input int k, input logic [15:0] p);
    real r;
    int  v;
    case (k)
      0: return p[15:8];
      1: begin
        r = 127.0 * $sin(6.283185307179586 * real'(p) / 65536.0);
        v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        return 8'(v);
      end
      2: return p[15] ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit msbAt(input int i);
    logic [7:0] s;
    s = sampleOf(kind, ph0 + 16'(i) * fcw);
    return s[7];
  endfunction

  function automatic bit edgeAt(input int i);
    return msbAt(i) && !msbAt(i - 1);
  endfunction

  // Reference: first rising crossing after the arming cycle aligns, then count crossings
  // in the following 2^G samples; no crossing within 2^G samples means no signal.
  task automatic model(input int g0, input int c0, output exp_t e, output int a);
    int cnt;
    int v;
    a = -1;
    for (int j = 1; j <= N; j++) begin
      if (edgeAt(g0 + j)) begin
        a = j;
        break;
      end
    end
    if (a < 0) begin
      e.fcw = 16'h0; e.nosig = 1'b1; e.stamp = c0 + N + 1;
    end else begin
      cnt = 0;
      for (int j = a + 1; j <= a + N; j++) if (edgeAt(g0 + j)) cnt++;
      v = cnt * (1 << (16 - G));
      e.fcw = (v > 65535) ? 16'hFFFF : 16'(v);
      e.nosig = 1'b0;
      e.stamp = c0 + a + N + 1;
    end
  endtask

  task automatic cyc(input bit en, input bit st, input bit ab);
    @(negedge clk);
    bus.sample_in  = sampleOf(kind, ph0 + 16'(genStep) * fcw);
    bus.enable     = en;
    bus.start      = st;
    bus.abort      = ab;
    bus.continuous = cont;
    bus.byte_sel   = bsel;
    @(posedge clk);
    if (en) begin
      enCnt++;
      genStep++;
    end
  endtask

  task automatic setWave(input int k, input logic [15:0] f, input logic [15:0] p);
    kind = k; fcw = f; ph0 = p; genStep = 0;
  endtask

  task automatic startMeas(output exp_t e, output int a);
    model(genStep, enCnt, e, a);
    q.push_back(e);
    cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic waitDone(input string nm, input int budget, input bit randEn);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      if (randEn) bsel = 1'($urandom);
      cyc(randEn ? ($urandom_range(7) != 0) : 1'b1, 1'b0, 1'b0);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=pending%0d expected=pending0", nm, q.size());
      q.delete();
    end
    bsel = 1'b0;
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic readBack(input string nm, input logic [15:0] exp);
    bsel = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    #1 chk({nm, "_lo"}, {24'h0, bus.data_out}, {24'h0, exp[7:0]});
    bsel = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    #1 chk({nm, "_hi"}, {24'h0, bus.data_out}, {24'h0, exp[15:8]});
    bsel = 1'b0;
  endtask

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (bus.done && !prevDone) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=done expected=no_done cycle=%0d", enCnt);
        end else begin
          me = q.pop_front();
          chk("done_cycle", enCnt, me.stamp);
          chk("done_data", {24'h0, bus.data_out},
              {24'h0, (bus.byte_sel ? me.fcw[15:8] : me.fcw[7:0])});
          chk("done_no_signal", {31'h0, bus.no_signal}, {31'h0, me.nosig});
          chk("done_result_valid", {31'h0, bus.result_valid}, 32'h1);
          lowCheckAt = enCnt + 1;
        end
      end
      if (lowCheckAt >= 0 && enCnt == lowCheckAt) begin
        chk("done_single_cycle", {31'h0, bus.done}, 32'h0);
        lowCheckAt = -1;
      end
    end
    prevDone = bus.done;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e, e2;
    int   a, a2;
    bus.enable = 1'b0; bus.sample_in = 8'h0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.continuous = 1'b0; bus.byte_sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_result_valid", {31'h0, bus.result_valid}, 32'h0);
    chk("rst_no_signal", {31'h0, bus.no_signal}, 32'h0);
    chk("rst_data_out", {24'h0, bus.data_out}, 32'h0);
    rst_n = 1'b1;

    // Sawtooth, period 256
    setWave(0, 16'h0100, 16'h0000);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    startMeas(e, a);
    #1 chk("saw_busy", {31'h0, bus.busy}, 32'h1);
    waitDone("saw", 2 * N + 100, 1'b0);
    readBack("saw_fcw", 16'h0100);

    // Sine, period 1024
    setWave(1, 16'h0040, 16'($urandom));
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    startMeas(e, a);
    waitDone("sine", 2 * N + 100, 1'b0);
    readBack("sine_fcw", 16'h0040);
    chk("sine_no_signal", {31'h0, bus.no_signal}, 32'h0);
    chk("sine_result_valid", {31'h0, bus.result_valid}, 32'h1);

    // Square toggling every cycle
    setWave(2, 16'h8000, 16'h0000);
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    startMeas(e, a);
    waitDone("square", 2 * N + 100, 1'b0);
    readBack("square_fcw", 16'h8000);

    // Abort at gate index 1000, with an ignored start earlier in the gate
    setWave(0, 16'h0100, 16'h0000);
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    startMeas(e, a);
    for (int i = 1; i < a + 1000; i++) begin
      if (i == a + 500) begin
        cyc(1'b1, 1'b1, 1'b0);
        #1 chk("start_in_gate_busy", {31'h0, bus.busy}, 32'h1);
      end else begin
        cyc(1'b1, 1'b0, 1'b0);
      end
    end
    cyc(1'b1, 1'b0, 1'b1);
    #1 chk("abort_busy", {31'h0, bus.busy}, 32'h0);
    void'(q.pop_back());
    repeat (N) cyc(1'b1, 1'b0, 1'b0);
    readBack("abort_keeps_fcw", 16'h8000);
    chk("abort_result_valid", {31'h0, bus.result_valid}, 32'h0);

    // Constant zero: timeout
    setWave(3, 16'h0000, 16'h0000);
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    startMeas(e, a);
    waitDone("const", 2 * N + 100, 1'b0);
    readBack("const_fcw", 16'h0000);
    chk("const_no_signal", {31'h0, bus.no_signal}, 32'h1);

    // Enable held low 500 cycles mid-gate
    setWave(0, 16'h0100, 16'h0000);
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    startMeas(e, a);
    repeat (a + 2000) cyc(1'b1, 1'b0, 1'b0);
    repeat (500) cyc(1'b0, 1'b0, 1'b0);
    waitDone("freeze", 2 * N + 100, 1'b0);
    readBack("freeze_fcw", 16'h0100);

    // Continuous: two back-to-back results, then back to idle
    cont = 1'b1;
    startMeas(e, a);
    model(genStep - 1 + (e.stamp - (enCnt - 1)), e.stamp, e2, a2);
    q.push_back(e2);
    for (int n = 0; n < 2 * N + 100 && q.size() > 1; n++) cyc(1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    cont = 1'b0;
    waitDone("continuous", 2 * N + 100, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    #1 chk("continuous_idle_busy", {31'h0, bus.busy}, 32'h0);
    readBack("continuous_fcw", 16'h0100);

    // Randomized waveforms, phases and enable gaps
    for (int r = 0; r < 3; r++) begin
      setWave(int'($urandom_range(2)), 16'($urandom_range(16'h7FFF, 16'h0100)), 16'($urandom));
      repeat (1 + $urandom_range(5)) cyc(1'b1, 1'b0, 1'b0);
      startMeas(e, a);
      waitDone("random", 3 * N, 1'b1);
      readBack("random_fcw", e.fcw);
    end

    // Asynchronous reset mid-gate, then a fresh measurement
    setWave(0, 16'h0100, 16'h0000);
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    startMeas(e, a);
    repeat (a + 1500) cyc(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'h0, bus.busy}, 32'h0);
    chk("arst_result_valid", {31'h0, bus.result_valid}, 32'h0);
    chk("arst_no_signal", {31'h0, bus.no_signal}, 32'h0);
    chk("arst_done", {31'h0, bus.done}, 32'h0);
    chk("arst_data_out", {24'h0, bus.data_out}, 32'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    startMeas(e, a);
    waitDone("after_reset", 2 * N + 100, 1'b0);
    readBack("after_reset_fcw", 16'h0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
